// File: rtl/button_gesture_fsm_if.sv
// Button gesture bus: debounced button in, gesture strobes and status levels out.
// Latency: none, plain wires between the debouncer, the classifier and the control logic.
// Backpressure: none; strobes are single-cycle and the consumer must take them when they fire.
interface button_gesture_fsm_if;
  logic i_level;   // debounced switch level, 1 = pressed
  logic i_rise;    // one-cycle pulse at debounced press start
  logic o_short;   // one-cycle strobe: single short press completed
  logic o_long;    // one-cycle strobe: press reached the long threshold
  logic o_double;  // one-cycle strobe: second press started inside the gap window
  logic o_held;    // level: long press still held
  logic o_busy;    // level: classifier not idle

  // Side that drives the button and consumes the events (debouncer / bench).
  modport master (
    output i_level,
    output i_rise,
    input  o_short,
    input  o_long,
    input  o_double,
    input  o_held,
    input  o_busy
  );

  // Classifier side.
  modport slave (
    input  i_level,
    input  i_rise,
    output o_short,
    output o_long,
    output o_double,
    output o_held,
    output o_busy
  );
endinterface

// File: rtl/button_gesture_fsm.sv
// Classifies one debounced button into short-press, long-press and double-click events.
// Latency: strobes and status levels are registered, one cycle after the deciding cycle.
// Backpressure: none; events are fire-and-forget single-cycle strobes.
module button_gesture_fsm #(
  parameter int LONG_TICKS = 50_000_000,  // press length for a long press, >= 2
  parameter int GAP_TICKS  = 25_000_000   // max idle gap after release for a double, >= 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  button_gesture_fsm_if.slave bus
);

  localparam int MAX_TICKS = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_HELD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            level_q;
  logic            fall;
  logic            short_d;
  logic            long_d;
  logic            double_d;
  logic            short_q;
  logic            long_q;
  logic            double_q;
  logic            held_q;
  logic            busy_q;

  // Release is the debounced level dropping relative to its one-cycle-old copy.
  assign fall = level_q & ~bus.i_level;

  // State, counter, level history and registered outputs; reset aborts silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= bus.i_level;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= (state_d == ST_HELD);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // Next-state and strobe decision; each transition raises at most one strobe.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A level already high out of reset, or a stray release, is ignored here.
        if (bus.i_rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          // Releasing in the very cycle the threshold is hit skips HELD entirely.
          state_d = fall ? ST_IDLE : ST_HELD;
        end else if (fall) begin
          state_d = ST_GAP;
        end
      end
      ST_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      ST_GAP: begin
        // A second press on the timeout cycle still counts as a double.
        if (bus.i_rise) begin
          double_d = 1'b1;
          state_d  = ST_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        // The second press of a double is swallowed whatever its length.
        if (fall) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tick counter: restarts on any state change, counts in PRESS1/GAP, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == ST_PRESS1) || (state_q == ST_GAP)) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.o_short  = short_q;
  assign bus.o_long   = long_q;
  assign bus.o_double = double_q;
  assign bus.o_held   = held_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_button_gesture_fsm.sv
// Self-checking bench for button_gesture_fsm with LONG_TICKS=8, GAP_TICKS=5.
// Cycle k starts at the k-th rising edge after reset release; inputs change 1 time unit
// after that edge and outputs are sampled on the falling edge of the same cycle.
module tb_button_gesture_fsm;
  localparam int LONG = 8;
  localparam int GAP  = 5;
  localparam int NCYC = 1024;

  logic i_clk;
  logic i_rst_n;

  button_gesture_fsm_if bus ();

  button_gesture_fsm #(
    .LONG_TICKS (LONG),
    .GAP_TICKS  (GAP)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus and expected strobe tables.
  logic lv [0:NCYC-1];
  logic rs [0:NCYC-1];
  bit   exp_s [0:NCYC-1];
  bit   exp_l [0:NCYC-1];
  bit   exp_d [0:NCYC-1];

  task automatic clear_stim();
    for (int k = 0; k < NCYC; k++) begin
      lv[k] = 1'b0; rs[k] = 1'b0;
      exp_s[k] = 1'b0; exp_l[k] = 1'b0; exp_d[k] = 1'b0;
    end
  endtask

  // Press: rise pulse at p, level high p..f-1, low from f (release seen at f).
  task automatic add_press(input int p, input int f);
    rs[p] = 1'b1;
    for (int k = p; k < f; k++) lv[k] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    bus.i_level = 1'b0;
    bus.i_rise  = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Apply stimulus for cycle c and return at the sampling point of cycle c.
  task automatic drive_cycle(input int c);
    @(posedge i_clk);
    #1;
    bus.i_level = lv[c];
    bus.i_rise  = rs[c];
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    clear_stim();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    bus.i_level = 1'b0;
    bus.i_rise  = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state outs=%b expected=00000",
               {bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    add_press(2, 300);
    for (int c = 0; c <= 5; c++) drive_cycle(c);
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy_before got=%b expected=1", bus.o_busy);
    end
    // Abort mid-PRESS1, well before the long threshold.
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async outs=%b expected=00000",
               {bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // Level still high on release, then dropped: that release must be ignored in IDLE.
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk);
      #1;
      bus.i_level = (c < 3);
      bus.i_rise  = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d outs=%b expected=00000", c,
                 {bus.o_short, bus.o_long, bus.o_double, bus.o_held, bus.o_busy});
      end
    end
  endtask

  task automatic test_short();
    do_reset();
    clear_stim();
    add_press(10, 14);
    for (int c = 0; c < 30; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {(c == 20), 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL short_strobes c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {(c == 20), 2'b00});
      end
      if (c != 20) begin
        n_checks++;
        if (bus.o_busy !== ((c >= 11) && (c <= 19))) begin
          n_fail++;
          $display("FAIL short_busy c=%0d got=%b expected=%b", c, bus.o_busy,
                   ((c >= 11) && (c <= 19)));
        end
      end
    end
  endtask

  task automatic test_long();
    do_reset();
    clear_stim();
    add_press(10, 41);
    for (int c = 0; c < 50; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {1'b0, (c == 19), 1'b0}) begin
        n_fail++;
        $display("FAIL long_strobes c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {1'b0, (c == 19), 1'b0});
      end
      if (c != 41) begin
        n_checks++;
        if (bus.o_held !== ((c >= 19) && (c <= 40))) begin
          n_fail++;
          $display("FAIL long_held c=%0d got=%b expected=%b", c, bus.o_held,
                   ((c >= 19) && (c <= 40)));
        end
      end
    end
  endtask

  task automatic test_double();
    do_reset();
    clear_stim();
    add_press(10, 14);
    add_press(17, 47);
    for (int c = 0; c < 70; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {2'b00, (c == 18)}) begin
        n_fail++;
        $display("FAIL double_strobes c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {2'b00, (c == 18)});
      end
      if (c >= 48) begin
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL double_idle c=%0d busy=%b expected=0", c, bus.o_busy);
        end
      end
    end
  endtask

  task automatic test_gap_edge();
    // Second rise on the timeout cycle: double wins.
    do_reset();
    clear_stim();
    add_press(10, 14);
    add_press(19, 25);
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {2'b00, (c == 20)}) begin
        n_fail++;
        $display("FAIL gap_tie c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {2'b00, (c == 20)});
      end
    end
    // Second rise one cycle later: short fires, the new press starts a fresh PRESS1.
    do_reset();
    clear_stim();
    add_press(10, 14);
    add_press(20, 24);
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {((c == 20) || (c == 30)), 2'b00}) begin
        n_fail++;
        $display("FAIL gap_late c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {((c == 20) || (c == 30)), 2'b00});
      end
      if (c == 21) begin
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_late_repress busy=%b expected=1", bus.o_busy);
        end
      end
    end
  endtask

  task automatic test_long_fall_tie();
    do_reset();
    clear_stim();
    add_press(10, 18);
    for (int c = 0; c < 35; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double, bus.o_held} !== {1'b0, (c == 19), 2'b00}) begin
        n_fail++;
        $display("FAIL tie_outs c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double, bus.o_held}, {1'b0, (c == 19), 2'b00});
      end
      if (c >= 19) begin
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL tie_idle c=%0d busy=%b expected=0", c, bus.o_busy);
        end
      end
    end
  endtask

  // Random press trains; expected events come from gesture rules on press times.
  task automatic test_random(input int np);
    int p[$];
    int f[$];
    int t;
    int d;
    int i;
    int len;
    do_reset();
    clear_stim();
    t = 3;
    for (int k = 0; k < np; k++) begin
      t = t + $urandom_range(1, 8);
      d = $urandom_range(1, 12);
      p.push_back(t);
      f.push_back(t + d);
      add_press(t, t + d);
      t = t + d;
    end
    i = 0;
    while (i < np) begin
      if (f[i] - p[i] >= LONG) begin
        // Held for the full threshold (release on the threshold cycle included).
        exp_l[p[i] + LONG + 1] = 1'b1;
        i = i + 1;
      end else if ((i + 1 < np) && (p[i + 1] <= f[i] + GAP)) begin
        exp_d[p[i + 1] + 1] = 1'b1;
        i = i + 2;
      end else begin
        exp_s[f[i] + GAP + 1] = 1'b1;
        i = i + 1;
      end
    end
    len = t + GAP + 10;
    for (int c = 0; c < len; c++) begin
      drive_cycle(c);
      n_checks++;
      if ({bus.o_short, bus.o_long, bus.o_double} !== {exp_s[c], exp_l[c], exp_d[c]}) begin
        n_fail++;
        $display("FAIL random c=%0d got=%b expected=%b", c,
                 {bus.o_short, bus.o_long, bus.o_double}, {exp_s[c], exp_l[c], exp_d[c]});
      end
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    bus.i_level = 1'b0;
    bus.i_rise  = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_edge();
    test_long_fall_tie();
    test_random(25);
    test_random(25);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
